// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer. Paces ball steps from frame ticks,
// detects goals, keeps score and runs IDLE/SERVE/PLAY/POINT/GAMEOVER.
// Optional feature macro: PONG_SPEEDUP_EN (paddle hits shorten the step period).
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter logic [9:0]  LEFT_GOAL      = 10'd4,
  parameter logic [9:0]  RIGHT_GOAL     = 10'd635,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned PERIOD_INIT    = 4,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ballX,
  input  logic       paddle_hit,
  output logic       update_ball,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } matchState_t;

  localparam logic [3:0] WIN_W    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_W  = 8'(SERVE_FRAMES);
  localparam logic [3:0] PERIOD_W = 4'(PERIOD_INIT);
  localparam logic [3:0] HITS_W   = 4'(HITS_PER_LEVEL);

  matchState_t curState, nextState;
  logic [3:0]  scoreL, scoreLNext;
  logic [3:0]  scoreR, scoreRNext;
  logic        serveDir, serveDirNext;
  logic        winnerQ, winnerNext;
  logic        updBall, updBallNext;
  logic        ballLoad, ballLoadNext;
  logic        gameOverQ;
  logic [3:0]  frameCnt, frameCntNext;
  logic [7:0]  serveCnt, serveCntNext;
  logic [3:0]  period;
  logic        enterServe;

`ifdef PONG_SPEEDUP_EN
  logic [3:0]  periodNext;
  logic [3:0]  hitCnt, hitCntNext;
`else
  // Without speed-up the period is fixed and paddle hits carry no meaning.
  logic        unusedHit;
  assign period    = PERIOD_W;
  assign unusedHit = paddle_hit ^ (HITS_W == 4'd0);
`endif

  // Register every piece of match state; reset returns the whole block to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      curState  <= IDLE;
      scoreL    <= 4'd0;
      scoreR    <= 4'd0;
      serveDir  <= 1'b0;
      winnerQ   <= 1'b0;
      updBall   <= 1'b0;
      ballLoad  <= 1'b0;
      gameOverQ <= 1'b0;
      frameCnt  <= 4'd0;
      serveCnt  <= 8'd0;
`ifdef PONG_SPEEDUP_EN
      period    <= PERIOD_W;
      hitCnt    <= 4'd0;
`endif
    end else begin
      curState  <= nextState;
      scoreL    <= scoreLNext;
      scoreR    <= scoreRNext;
      serveDir  <= serveDirNext;
      winnerQ   <= winnerNext;
      updBall   <= updBallNext;
      ballLoad  <= ballLoadNext;
      gameOverQ <= (nextState == GAMEOVER);
      frameCnt  <= frameCntNext;
      serveCnt  <= serveCntNext;
`ifdef PONG_SPEEDUP_EN
      period    <= periodNext;
      hitCnt    <= hitCntNext;
`endif
    end
  end

  // Next-state and next-output logic for the match flow.
  always_comb begin
    nextState    = curState;
    scoreLNext   = scoreL;
    scoreRNext   = scoreR;
    serveDirNext = serveDir;
    winnerNext   = winnerQ;
    updBallNext  = 1'b0;
    ballLoadNext = 1'b0;
    frameCntNext = frameCnt;
    serveCntNext = serveCnt;
    enterServe   = 1'b0;
`ifdef PONG_SPEEDUP_EN
    periodNext   = period;
    hitCntNext   = hitCnt;
`endif

    case (curState)
      IDLE: begin
        if (start) enterServe = 1'b1;
      end
      GAMEOVER: begin
        if (start) begin
          scoreLNext = 4'd0;
          scoreRNext = 4'd0;
          enterServe = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          serveCntNext = serveCnt + 8'd1;
          if (serveCnt + 8'd1 == SERVE_W) begin
            nextState    = PLAY;
            frameCntNext = 4'd0;
          end
        end
      end
      PLAY: begin
        // A goal takes priority: the tick and any paddle hit in that cycle are dropped.
        if (ballX <= LEFT_GOAL) begin
          scoreRNext   = scoreR + 4'd1;
          serveDirNext = 1'b0;
          nextState    = POINT;
        end else if (ballX >= RIGHT_GOAL) begin
          scoreLNext   = scoreL + 4'd1;
          serveDirNext = 1'b1;
          nextState    = POINT;
        end else begin
          if (frame_tick) begin
            if (frameCnt == 4'd0) begin
              updBallNext  = 1'b1;
              frameCntNext = period - 4'd1;
            end else begin
              frameCntNext = frameCnt - 4'd1;
            end
          end
`ifdef PONG_SPEEDUP_EN
          if (paddle_hit) begin
            if (hitCnt + 4'd1 == HITS_W) begin
              hitCntNext = 4'd0;
              if (period > 4'd1) periodNext = period - 4'd1;
            end else begin
              hitCntNext = hitCnt + 4'd1;
            end
          end
`endif
        end
      end
      POINT: begin
        if (scoreL == WIN_W) begin
          nextState  = GAMEOVER;
          winnerNext = 1'b0;
        end else if (scoreR == WIN_W) begin
          nextState  = GAMEOVER;
          winnerNext = 1'b1;
        end else begin
          enterServe = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase

    // Serve entry: load the ball and restart serve pacing.
    if (enterServe) begin
      nextState    = SERVE;
      ballLoadNext = 1'b1;
      serveCntNext = 8'd0;
`ifdef PONG_SPEEDUP_EN
      periodNext   = PERIOD_W;
      hitCntNext   = 4'd0;
`endif
    end
  end

  assign state       = curState;
  assign score_l     = scoreL;
  assign score_r     = scoreR;
  assign serve_dir   = serveDir;
  assign winner      = winnerQ;
  assign update_ball = updBall;
  assign ball_load   = ballLoad;
  assign game_over   = gameOverQ;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with a behavioural match model.
module tb_pong_match_ctrl;

  localparam int WIN          = 7;
  localparam int LGOAL        = 4;
  localparam int RGOAL        = 635;
  localparam int SERVE_FRAMES = 3;
  localparam int PINIT        = 4;
  localparam int HITS_LVL     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ballX = 10'd300;
  logic       paddle_hit = 1'b0;
  logic       update_ball, ball_load, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .LEFT_GOAL(10'd4), .RIGHT_GOAL(10'd635),
    .SERVE_FRAMES(SERVE_FRAMES), .PERIOD_INIT(PINIT), .HITS_PER_LEVEL(HITS_LVL)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .ballX(ballX),
    .paddle_hit(paddle_hit), .update_ball(update_ball), .ball_load(ball_load),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r), .state(state),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference model: match phase numbers 0..4, strobes scheduled by absolute tick index.
  int mState, mScoreL, mScoreR, mServeDir, mWinner, mUpd, mLoad;
  int mPeriod, mHits, mServeTicks, mPlayTicks, mNextStrobe;

  task automatic model_reset();
    mState = 0; mScoreL = 0; mScoreR = 0; mServeDir = 0; mWinner = 0;
    mUpd = 0; mLoad = 0; mPeriod = PINIT; mHits = 0; mServeTicks = 0;
    mPlayTicks = 0; mNextStrobe = 1;
  endtask

  task automatic model_serve();
    mState = 1; mLoad = 1; mPeriod = PINIT; mHits = 0; mServeTicks = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input int bx, input bit hit);
    mUpd = 0; mLoad = 0;
    case (mState)
      0: if (st) model_serve();
      4: if (st) begin mScoreL = 0; mScoreR = 0; model_serve(); end
      1: if (tk) begin
           mServeTicks++;
           if (mServeTicks == SERVE_FRAMES) begin
             mState = 2; mPlayTicks = 0; mNextStrobe = 1;
           end
         end
      2: begin
           if (bx <= LGOAL) begin
             mScoreR++; mServeDir = 0; mState = 3;
           end else if (bx >= RGOAL) begin
             mScoreL++; mServeDir = 1; mState = 3;
           end else begin
             if (tk) begin
               mPlayTicks++;
               if (mPlayTicks == mNextStrobe) begin
                 mUpd = 1; mNextStrobe = mNextStrobe + mPeriod;
               end
             end
`ifdef PONG_SPEEDUP_EN
             if (hit) begin
               mHits++;
               if (mHits == HITS_LVL) begin
                 mHits = 0;
                 if (mPeriod > 1) mPeriod--;
               end
             end
`endif
           end
         end
      3: begin
           if (mScoreL == WIN) begin mState = 4; mWinner = 0; end
           else if (mScoreR == WIN) begin mState = 4; mWinner = 1; end
           else model_serve();
         end
      default: mState = 0;
    endcase
  endtask

  function automatic logic [15:0] dut_vec();
    return {state, score_l, score_r, serve_dir, winner, update_ball, ball_load, game_over};
  endfunction

  function automatic logic [15:0] model_vec();
    return {3'(mState), 4'(mScoreL), 4'(mScoreR), 1'(mServeDir), 1'(mWinner),
            1'(mUpd), 1'(mLoad), 1'(mState == 4)};
  endfunction

  // Apply one cycle of inputs, advance the model, and settle just after the edge.
  task automatic drive(input bit r, input bit st, input bit tk, input int bx, input bit hit);
    rst = r; start = st; frame_tick = tk; ballX = 10'(bx); paddle_hit = hit;
    if (!r) model_reset();
    else model_step(st, tk, bx, hit);
    @(posedge clk);
    #1;
  endtask

  function automatic int mid_x();
    return int'($urandom_range(600, 20));
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1);
      got = dut_vec(); checks++;
      if (got !== 16'h0000) begin
        errors++; $display("FAIL reset cyc%0d got=%h want=0000", i, got);
      end
    end
    drive(1, 0, 1, 300, 0);
    got = dut_vec(); checks++;
    if (got !== model_vec()) begin
      errors++; $display("FAIL reset_idle got=%h want=%h", got, model_vec());
    end
  endtask

  task automatic test_serve_play();
    logic [15:0] got;
    int nUpd = 0;
    drive(1, 1, 0, 300, 0);
    got = dut_vec(); checks++;
    if (got !== model_vec() || ball_load !== 1'b1) begin
      errors++; $display("FAIL serve_entry got=%h want=%h", got, model_vec());
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, (i % 2) == 0, mid_x(), 0);
      nUpd += int'(update_ball);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL serve_play cyc%0d got=%h want=%h", i, got, model_vec());
      end
    end
    // 20 ticks total, 3 spent in SERVE, 17 in PLAY at period 4: strobes on ticks 1,5,9,13,17.
    checks++;
    if (nUpd != 5) begin
      errors++; $display("FAIL serve_play_strobes got=%0d want=5", nUpd);
    end
  endtask

  task automatic test_goals();
    logic [15:0] got;
    int goals[3] = '{RGOAL, LGOAL, RGOAL};
    for (int g = 0; g < 3; g++) begin
      drive(1, 0, 0, goals[g], 0);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL goal%0d got=%h want=%h", g, got, model_vec());
      end
      for (int i = 0; i < 6; i++) begin
        drive(1, 0, i > 0, mid_x(), 0);
        got = dut_vec(); checks++;
        if (got !== model_vec()) begin
          errors++; $display("FAIL goal%0d_after cyc%0d got=%h want=%h", g, i, got, model_vec());
        end
      end
    end
  endtask

  task automatic test_game_over();
    logic [15:0] got;
    int n = 0;
    while (mState != 4 && n < 300) begin
      if (mState == 2) drive(1, 0, 0, RGOAL + int'($urandom_range(388, 0)), 0);
      else drive(1, 0, 1, mid_x(), 0);
      n++;
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL game_over cyc%0d got=%h want=%h", n, got, model_vec());
      end
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || score_l !== 4'd7) begin
      errors++; $display("FAIL game_over_final got=%b/%b/%0d want=1/0/7", game_over, winner, score_l);
    end
    drive(1, 0, 1, 300, 0);
    drive(1, 1, 0, 300, 0);
    got = dut_vec(); checks++;
    if (got !== model_vec() || score_l !== 4'd0 || state !== 3'd1) begin
      errors++; $display("FAIL restart got=%h want=%h", got, model_vec());
    end
  endtask

  task automatic test_speedup();
    logic [15:0] got;
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 300, 0);
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, $urandom_range(1, 0) == 1, mid_x(), $urandom_range(2, 0) == 0);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL speedup cyc%0d got=%h want=%h per=%0d", i, got, model_vec(), mPeriod);
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 1, mid_x(), 0);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL speedup_steady cyc%0d got=%h want=%h", i, got, model_vec());
      end
    end
  endtask

  task automatic test_goal_hit_tick();
    logic [15:0] got;
    for (int i = 0; i < 3; i++) drive(1, 0, 1, mid_x(), 1);
    drive(1, 0, 1, LGOAL, 1);
    got = dut_vec(); checks++;
    if (got !== model_vec() || update_ball !== 1'b0 || state !== 3'd3) begin
      errors++; $display("FAIL goal_hit_tick got=%h want=%h", got, model_vec());
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, mid_x(), (i % 3) == 0);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL goal_hit_after cyc%0d got=%h want=%h", i, got, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    drive(1, 1, 0, 300, 0);
    drive(1, 0, 1, 300, 0);
    drive(0, 0, 1, 300, 0);
    got = dut_vec(); checks++;
    if (got !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_serve got=%h want=0000", got);
    end
    drive(1, 1, 0, 300, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 300, 0);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL reach_play got=%0d want=2", state);
    end
    drive(0, 1, 1, LGOAL, 1);
    got = dut_vec(); checks++;
    if (got !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_play got=%h want=0000", got);
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    int bx;
    for (int i = 0; i < 3000; i++) begin
      bx = ($urandom_range(24, 0) == 0) ? int'($urandom_range(1023, 0)) : mid_x();
      drive($urandom_range(400, 0) != 0, $urandom_range(7, 0) == 0,
            $urandom_range(2, 0) == 0, bx, $urandom_range(3, 0) == 0);
      got = dut_vec(); checks++;
      if (got !== model_vec()) begin
        errors++; $display("FAIL random cyc%0d got=%h want=%h", i, got, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve_play();
    test_goals();
    test_game_over();
    test_speedup();
    test_goal_hit_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong datapath: paces ball motion by issuing one-cycle `update_ball` strobes (wired to the ball block's `ResetCollision`) at a frame-derived rate, detects goals from the ball position, keeps score and runs the serve / play / point / game-over flow. Sits between the video timing generator (frame tick), the ball block and the score display.

## Interface
- `WIN_SCORE`, 7: points that end the match (1..15).
- `LEFT_GOAL`, 10'd4: `ballX <= LEFT_GOAL` is a point for the right player.
- `RIGHT_GOAL`, 10'd635: `ballX >= RIGHT_GOAL` is a point for the left player.
- `SERVE_FRAMES`, 60: frame ticks spent in SERVE before play (1..255).
- `PERIOD_INIT`, 4: frames per ball step at serve (1..15).
- `HITS_PER_LEVEL`, 4: paddle hits per speed-up level (1..15).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame, after the active area.
- `start` in 1: level; starts a match from IDLE or GAMEOVER.
- `ballX` in 10: current ball X.
- `paddle_hit` in 1: one-cycle pulse when the ball bounces off a paddle.
- `update_ball` out 1: one-cycle strobe; ball steps one pixel and collision flags clear.
- `ball_load` out 1: one-cycle strobe; ball block loads centre position and `serve_dir`.
- `serve_dir` out 1: 0 = serve rightward, 1 = leftward.
- `score_l`, `score_r` out 4: scores.
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- `game_over` out 1: high in GAMEOVER. `winner` out 1: 0 = left, 1 = right; valid while `game_over`.

## Operation
- Reset (`rst`=0 at a clock edge): state IDLE; scores 0; `serve_dir`=0; `winner`=0; all strobes 0; period=`PERIOD_INIT`; frame counter, hit counter and serve counter 0. Reset overrides everything, including mid-serve or mid-point.
- IDLE: `start`=1 → SERVE. GAMEOVER: `start`=1 → clear scores → SERVE. `serve_dir` is kept.
- SERVE entry: `ball_load` pulses once; period reloads to `PERIOD_INIT`; hit counter and serve counter clear. Each `frame_tick` increments the serve counter. At `SERVE_FRAMES` → PLAY with frame counter 0.
- PLAY: on every `frame_tick`, if frame counter == 0, `update_ball` pulses and the counter loads period−1. Otherwise the counter decrements. `ballX` is compared every cycle:
  - `ballX <= LEFT_GOAL`: `score_r`+1, `serve_dir`=0.
  - `ballX >= RIGHT_GOAL`: `score_l`+1, `serve_dir`=1.
  - Either goal → POINT.
- POINT: one cycle. If the updated score == `WIN_SCORE` → GAMEOVER and `winner` = scorer. Else → SERVE.
- Goal and `paddle_hit` in the same cycle: the goal wins and the hit is discarded. `frame_tick` on a goal cycle produces no `update_ball`.
- Scores never exceed `WIN_SCORE`. All arithmetic is unsigned. Counters are sized to their parameter maxima, with no wrap.
- `update_ball` and `ball_load` are only ever asserted in PLAY and on SERVE entry respectively. They are never asserted together.

## Timing
- All outputs are registered.
- `update_ball` is high in the cycle after the `frame_tick` it answers.
- `ball_load` is high in the first cycle that `state`=SERVE.
- A goal seen at edge N gives `state`=POINT and updated scores after edge N. SERVE or GAMEOVER follows after edge N+1.
- `start` seen at edge N gives `state`=SERVE after edge N.
- With period P, successive `update_ball` strobes are exactly P frame ticks apart. The first strobe follows the first `frame_tick` in PLAY.

## Configuration
- `PONG_SPEEDUP_EN` defined:
  - In PLAY, each `paddle_hit` increments the hit counter.
  - When the counter reaches `HITS_PER_LEVEL`, it clears and period decrements, floored at 1.
  - A new period takes effect at the next counter reload.
- `PONG_SPEEDUP_EN` undefined: `paddle_hit` is ignored, the hit counter is removed, and period stays `PERIOD_INIT`.

## Test plan
- Reset, `start` pulse, `SERVE_FRAMES`=3 → `ball_load` pulses once → PLAY after the 3rd `frame_tick` → `update_ball` on ticks 1, 5, 9 (`PERIOD_INIT`=4).
- In PLAY, drive `ballX`=4 → POINT → `score_r`=1, `serve_dir`=1→0 → SERVE with a fresh `ball_load`. Repeat with `ballX`=635 → `score_l`=1, `serve_dir`=1.
- Left scores 7 times → after the 7th POINT, `state`=GAMEOVER, `game_over`=1, `winner`=0. `start` → scores 0, SERVE.
- With `PONG_SPEEDUP_EN`: 4 `paddle_hit` pulses → period 3, then 4 more → 2, then 4 more → 1, then 4 more → still 1. `update_ball` appears on every tick at period 1. Without the macro: period stays 4.
- Goal, `paddle_hit` and `frame_tick` in the same cycle → score increments, no `update_ball`, hit counter unchanged.
- Assert `rst`=0 mid-SERVE and mid-PLAY → next cycle: IDLE, scores 0, no strobes, `game_over`=0.
